// File: rtl/i2s_stream_scheduler_if.sv
// i2s_stream_scheduler_if
//  Bundles the two producer handshakes and the word/enable bus towards the
//  i2sMaster transmitter.
//  master : producer/consumer side (drives srcN_valid/left/right, observes the rest)
//  slave  : scheduler side (drives srcN_ready, i2s_en, i2s_left/right, active_src, underrun)
interface i2s_stream_scheduler_if #(
    parameter int DATA_W = 16
);
    logic              src0_valid;
    logic [DATA_W-1:0] src0_left;
    logic [DATA_W-1:0] src0_right;
    logic              src0_ready;
    logic              src1_valid;
    logic [DATA_W-1:0] src1_left;
    logic [DATA_W-1:0] src1_right;
    logic              src1_ready;
    logic              i2s_en;
    logic [DATA_W-1:0] i2s_left;
    logic [DATA_W-1:0] i2s_right;
    logic              active_src;
    logic              underrun;

    modport master (
        output src0_valid, src0_left, src0_right,
        output src1_valid, src1_left, src1_right,
        input  src0_ready, src1_ready,
        input  i2s_en, i2s_left, i2s_right, active_src, underrun
    );

    modport slave (
        input  src0_valid, src0_left, src0_right,
        input  src1_valid, src1_left, src1_right,
        output src0_ready, src1_ready,
        output i2s_en, i2s_left, i2s_right, active_src, underrun
    );
endinterface

// File: rtl/i2s_stream_scheduler.sv
// i2s_stream_scheduler
//  Shares one i2sMaster transmitter between two stereo sources. Each source
//  has its own FWFT FIFO; once per LRCLK frame one source is chosen and its
//  stereo word is presented to the transmitter, whose enable is sequenced
//  through IDLE -> PRIME -> RUN -> DRAIN.
//  Ports:
//   clk      system clock (rising edge)
//   rst      asynchronous active-low reset
//   run_req  1 = stream, 0 = stop after the current frame
//   mode     00 src0, 01 src1, 10 round-robin, 11 src0 priority
//   LRCLK    word-select clock from i2sMaster (asynchronous)
//   mute     only with I2S_SCHED_MUTE_EN defined: zero the presented words
//   bus      i2s_stream_scheduler_if.slave (source handshakes, i2s outputs)
//  Build option: define I2S_SCHED_MUTE_EN to add the mute input.

// Per-source FIFO, first-word-fall-through, holds {left,right}.
module i2s_sched_fifo #(
    parameter int W     = 32,
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push,
    input  logic                   pop,
    input  logic [W-1:0]           wr_data,
    output logic [W-1:0]           rd_data,
    output logic [$clog2(DEPTH):0] count,
    output logic                   ready,
    output logic                   empty
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic          push_ok, pop_ok;

    assign ready   = (count != CW'(DEPTH));
    assign empty   = (count == '0);
    assign push_ok = push & ready;
    assign pop_ok  = pop & ~empty;
    assign rd_data = mem[rd_ptr];

    // Pointers wrap naturally since DEPTH is a power of two.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + 1'b1;
            if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
            case ({push_ok, pop_ok})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: ;
            endcase
        end
    end

    // Storage needs no reset: emptiness is tracked by count alone.
    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr] <= wr_data;
    end
endmodule

module i2s_stream_scheduler #(
    parameter int DATA_W      = 16,
    parameter int DEPTH       = 4,
    parameter int SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       run_req,
    input  logic [1:0] mode,
    input  logic       LRCLK,
`ifdef I2S_SCHED_MUTE_EN
    input  logic       mute,
`endif
    i2s_stream_scheduler_if.slave bus
);
    localparam int NSRC = 2;
    localparam int CW   = $clog2(DEPTH) + 1;
    localparam int WW   = 2 * DATA_W;

    typedef enum logic [1:0] {S_IDLE, S_PRIME, S_RUN, S_DRAIN} state_t;

    state_t                     state, state_nx;
    logic [NSRC-1:0]            in_valid, in_ready, pop, empty;
    logic [NSRC-1:0][WW-1:0]    in_data, rd_data;
    logic [NSRC-1:0][CW-1:0]    cnt;
    logic [SYNC_STAGES-1:0]     lr_sync;
    logic                       lr_prev, tick;
    logic                       en, serve, elig_ok, sel, rr, out_zero;
    logic [DATA_W-1:0]          left_q, right_q;
    logic                       active_q, underrun_q;

    // ---------------- source FIFOs ----------------
    assign in_valid   = {bus.src1_valid, bus.src0_valid};
    assign in_data[0] = {bus.src0_left, bus.src0_right};
    assign in_data[1] = {bus.src1_left, bus.src1_right};
    assign bus.src0_ready = in_ready[0];
    assign bus.src1_ready = in_ready[1];

    for (genvar g = 0; g < NSRC; g++) begin : g_src
        i2s_sched_fifo #(.W(WW), .DEPTH(DEPTH)) u_fifo (
            .clk     (clk),
            .rst     (rst),
            .push    (in_valid[g] & in_ready[g]),
            .pop     (pop[g]),
            .wr_data (in_data[g]),
            .rd_data (rd_data[g]),
            .count   (cnt[g]),
            .ready   (in_ready[g]),
            .empty   (empty[g])
        );
    end

    // ---------------- frame tick ----------------
    // Falling edge of the synchronised LRCLK marks the start of the left word.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            lr_sync <= '0;
            lr_prev <= 1'b0;
        end else begin
            lr_sync <= {lr_sync[SYNC_STAGES-2:0], LRCLK};
            lr_prev <= lr_sync[SYNC_STAGES-1];
        end
    end
    assign tick = lr_prev & ~lr_sync[SYNC_STAGES-1];

    // ---------------- control FSM ----------------
    always_comb begin
        case (mode)
            2'b00:   elig_ok = (cnt[0] >= CW'(DEPTH / 2));
            2'b01:   elig_ok = (cnt[1] >= CW'(DEPTH / 2));
            default: elig_ok = (cnt[0] >= CW'(DEPTH / 2)) || (cnt[1] >= CW'(DEPTH / 2));
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= S_IDLE;
        else      state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        en       = 1'b0;
        serve    = 1'b0;
        case (state)
            S_IDLE:  if (run_req) state_nx = S_PRIME;
            S_PRIME: begin
                if (!run_req)     state_nx = S_IDLE;
                else if (elig_ok) state_nx = S_RUN;
            end
            S_RUN: begin
                en    = 1'b1;
                serve = tick;
                if (!run_req) state_nx = S_DRAIN;
            end
            S_DRAIN: begin
                en    = 1'b1;
                serve = tick;
                if (tick) state_nx = S_IDLE;
            end
            default: state_nx = S_IDLE;
        endcase
    end

    // ---------------- source selection ----------------
    // Mode is only consumed when serve is high, so a change lands on the next frame.
    always_comb begin
        case (mode)
            2'b00:   sel = 1'b0;
            2'b01:   sel = 1'b1;
            2'b10:   sel = (empty[rr] && !empty[~rr]) ? ~rr : rr;
            default: sel = empty[0];
        endcase
        pop = '0;
        if (serve && !empty[sel]) pop[sel] = 1'b1;
    end

`ifdef I2S_SCHED_MUTE_EN
    assign out_zero = mute;
`else
    assign out_zero = 1'b0;
`endif

    // ---------------- presented word ----------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            left_q     <= '0;
            right_q    <= '0;
            active_q   <= 1'b0;
            underrun_q <= 1'b0;
            rr         <= 1'b0;
        end else begin
            underrun_q <= 1'b0;
            if (serve) begin
                active_q   <= sel;
                underrun_q <= empty[sel];
                if (empty[sel] || out_zero) begin
                    left_q  <= '0;
                    right_q <= '0;
                end else begin
                    {left_q, right_q} <= rd_data[sel];
                end
                // Round-robin pointer advances only on a real pop.
                if (mode == 2'b10 && !empty[sel]) rr <= ~rr;
            end
        end
    end

    assign bus.i2s_en     = en;
    assign bus.i2s_left   = left_q;
    assign bus.i2s_right  = right_q;
    assign bus.active_src = active_q;
    assign bus.underrun   = underrun_q;
endmodule
